// File: rtl/tree_layer_agg.sv
// Tree-layer aggregation engine.
// Streams per-slice counters, right-shifts each one, sums them in groups of
// GROUP_SIZE beats and stores every group sum in an internal RAM. Each stored
// sum is also emitted as a one-cycle beat, so one layer can feed the next.
// A registered read-back port gives access to the RAM in any state.
module tree_layer_agg #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int GROUP_SIZE = 8,
  parameter int SHIFT      = 3,
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 7
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              sum_valid,
  output logic [OUT_W-1:0]  sum_data,
  output logic [ADDR_W-1:0] sum_index,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic [ADDR_W:0]   entry_count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              sat
);

  // Eight guard bits cover up to 256 full-scale beats in one group.
  localparam int ACC_W = IN_W + 8;
  localparam int CNT_W = 9;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(GROUP_SIZE - 1);
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ACC_W-1:0]  SAT_MAX   = {{(ACC_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  beat_cnt;
  logic [OUT_W-1:0]  mem [DEPTH];

  logic [ACC_W-1:0]  term;
  logic [ACC_W-1:0]  acc_next;
  logic              over;
  logic [OUT_W-1:0]  stored;
  logic              accept;
  logic              close;
  logic [ADDR_W:0]   entry_next;
  logic              at_depth;

  // Handshake and status decode straight from the state register.
  assign in_ready = (state == ACCUM);
  assign busy     = (state == ACCUM);

  // Datapath: scaled term, running sum, saturation and group-close decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    term       = '0;
    acc_next   = '0;
    over       = 1'b0;
    stored     = '0;
    accept     = 1'b0;
    close      = 1'b0;
    entry_next = '0;
    at_depth   = 1'b0;

    term       = ACC_W'(in_data >> SHIFT);
    acc_next   = acc + term;
    over       = (acc_next > SAT_MAX);
    stored     = over ? {OUT_W{1'b1}} : acc_next[OUT_W-1:0];
    // A beat coinciding with start belongs to the aborted frame and is dropped.
    accept     = in_valid && in_ready && !start;
    close      = accept && ((beat_cnt == LAST_BEAT) || in_last);
    entry_next = entry_count + (ADDR_W + 1)'(1);
    at_depth   = (entry_next == DEPTH_C);
  end

  // Control state, counters, emitted sum beat, sticky flags and read port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      acc         <= '0;
      beat_cnt    <= '0;
      entry_count <= '0;
      sum_valid   <= 1'b0;
      sum_data    <= '0;
      sum_index   <= '0;
      rd_data     <= '0;
      done        <= 1'b0;
      full        <= 1'b0;
      sat         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      sum_valid <= 1'b0;

      if (start) begin
        // Start from any state opens a fresh frame; a partial group is discarded.
        state       <= ACCUM;
        acc         <= '0;
        beat_cnt    <= '0;
        entry_count <= '0;
        done        <= 1'b0;
        full        <= 1'b0;
        sat         <= 1'b0;
      end else if (accept) begin
        if (close) begin
          sum_valid   <= 1'b1;
          sum_data    <= stored;
          sum_index   <= entry_count[ADDR_W-1:0];
          entry_count <= entry_next;
          acc         <= '0;
          beat_cnt    <= '0;
          if (over) begin
            sat <= 1'b1;
          end
          if (in_last || at_depth) begin
            state <= DONE;
            done  <= 1'b1;
          end
          if (at_depth) begin
            full <= 1'b1;
          end
        end else begin
          acc      <= acc_next;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end

      // Read-first: this samples the RAM before any write on the same edge lands.
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

  // RAM write port, one entry per group close.
  // NOTE: the RAM array is deliberately left out of reset so it maps onto a
  // plain memory macro; contents survive Reset_n.
  always_ff @(posedge Clk) begin
    if (close) begin
      mem[entry_count[ADDR_W-1:0]] <= stored;
    end
  end

endmodule

// File: tb/tb_tree_layer_agg.sv
// Self-checking bench for tree_layer_agg: a scoreboard of expected sum beats
// built from a behavioural model, plus direct status and read-back checks.
// A second instance with DEPTH = 4, GROUP_SIZE = 1 exercises the full stop.
module tb_tree_layer_agg;

  logic        Clk = 1'b0;
  logic        Reset_n;

  // Main instance: default parameters.
  logic        start, in_valid, in_last, rd_en;
  logic [31:0] in_data;
  logic [6:0]  rd_addr;
  logic        in_ready, sum_valid, busy, done, full, sat;
  logic [15:0] sum_data, rd_data;
  logic [6:0]  sum_index;
  logic [7:0]  entry_count;

  // Small instance: DEPTH 4, GROUP_SIZE 1.
  logic        start4, in_valid4, in_last4, rd_en4;
  logic [31:0] in_data4;
  logic [1:0]  rd_addr4;
  logic        in_ready4, sum_valid4, busy4, done4, full4, sat4;
  logic [15:0] sum_data4, rd_data4;
  logic [1:0]  sum_index4;
  logic [2:0]  entry_count4;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] sb_q  [$];
  logic [31:0] sb_q4 [$];

  // Behavioural model of the main instance (GROUP_SIZE 8, SHIFT 3, OUT_W 16).
  longint      m_acc;
  int          m_cnt;
  int          m_idx;
  int          shadow [128];

  always #5 Clk = ~Clk;

  tree_layer_agg dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_index(sum_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .entry_count(entry_count), .busy(busy), .done(done), .full(full), .sat(sat)
  );

  tree_layer_agg #(.GROUP_SIZE(1), .DEPTH(4), .ADDR_W(2)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .sum_valid(sum_valid4), .sum_data(sum_data4), .sum_index(sum_index4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .entry_count(entry_count4), .busy(busy4), .done(done4), .full(full4), .sat(sat4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_start();
    m_acc = 0;
    m_cnt = 0;
    m_idx = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit last);
    int val;
    m_acc += longint'(d >> 3);
    m_cnt++;
    if (m_cnt == 8 || last) begin
      val = (m_acc > 65535) ? 65535 : int'(m_acc);
      sb_q.push_back({16'(m_idx), 16'(val)});
      shadow[m_idx] = val;
      m_idx++;
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  // Present one beat after an optional idle gap; bounded wait on in_ready.
  task automatic send_beat(input logic [31:0] d, input bit last, input int gap);
    int budget;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      tick();
      model_beat(d, last);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input int exp);
    rd_en   = 1'b1;
    rd_addr = 7'(addr);
    tick();
    rd_en   = 1'b0;
    check(tag, 64'(rd_data), 64'(exp));
  endtask

  // Scoreboard monitors: every sum beat must match the oldest expected entry.
  always @(negedge Clk) begin
    if (sum_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_sum", {16'(sum_index), sum_data}, 64'hDEAD);
      end else begin
        check("sum", {16'(sum_index), sum_data}, 64'(sb_q.pop_front()));
      end
    end
  end

  always @(negedge Clk) begin
    if (sum_valid4) begin
      if (sb_q4.size() == 0) begin
        check("unexpected_sum4", {16'(sum_index4), sum_data4}, 64'hDEAD);
      end else begin
        check("sum4", {16'(sum_index4), sum_data4}, 64'(sb_q4.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals [24];
    int          old_v;

    Reset_n  = 1'b0;
    start    = 1'b0; in_valid  = 1'b0; in_last  = 1'b0; in_data  = '0; rd_en  = 1'b0; rd_addr  = '0;
    start4   = 1'b0; in_valid4 = 1'b0; in_last4 = 1'b0; in_data4 = '0; rd_en4 = 1'b0; rd_addr4 = '0;
    model_start();
    for (int i = 0; i < 128; i++) shadow[i] = 0;
    repeat (2) tick();

    // Reset state.
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_flags", {done, full, sat, sum_valid}, 64'd0);
    check("rst_sum", {sum_index, sum_data}, 64'd0);
    check("rst_count_rd", {entry_count, rd_data}, 64'd0);
    Reset_n = 1'b1;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // 1: two full groups of 80.
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 16; i++) send_beat(32'd80, i == 15, 0);
    check("t1_done_with_last_sum", {done, sum_valid}, 64'b11);
    check("t1_entry_count", 64'(entry_count), 64'd2);
    check("t1_in_ready_done", 64'(in_ready), 64'd0);
    read_check("t1_rd0", 0, 80);
    read_check("t1_rd1", 1, 80);

    // 2: partial flush on in_last.
    pulse_start();
    check("t2_cleared", {done, entry_count}, 64'd0);
    send_beat(32'd16, 1'b0, 0);
    send_beat(32'd24, 1'b0, 0);
    send_beat(32'd40, 1'b1, 0);
    check("t2_done", 64'(done), 64'd1);
    check("t2_sat", 64'(sat), 64'd0);
    check("t2_entry_count", 64'(entry_count), 64'd1);

    // 3: saturation, sticky until the next start.
    pulse_start();
    for (int i = 0; i < 8; i++) send_beat(32'hFFFF_FFFF, i == 7, 0);
    check("t3_sat", 64'(sat), 64'd1);
    repeat (3) tick();
    check("t3_sat_sticky", 64'(sat), 64'd1);
    pulse_start();
    check("t3_sat_cleared", 64'(sat), 64'd0);
    send_beat(32'd8, 1'b1, 0);
    check("t3_small_sat", 64'(sat), 64'd0);

    // 4: full stop on the DEPTH 4, GROUP_SIZE 1 instance.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data4  = 32'((i + 1) * 8);
      in_valid4 = 1'b1;
      check("t4_in_ready", 64'(in_ready4), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) sb_q4.push_back({16'(i), 16'(i + 1)});
      tick();
    end
    in_valid4 = 1'b0;
    check("t4_full_done", {full4, done4}, 64'b11);
    check("t4_entry_count", 64'(entry_count4), 64'd4);
    repeat (2) tick();
    check("t4_sb_drain", 64'(sb_q4.size()), 64'd0);

    // 5: abort mid-group (beat on the start cycle ignored), then async reset.
    pulse_start();
    for (int i = 0; i < 5; i++) send_beat(32'd8, 1'b0, 0);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd8;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    model_start();
    check("t5_abort_count", 64'(entry_count), 64'd0);
    check("t5_abort_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 3; i++) send_beat(32'd8, 1'b0, 0);
    #1;
    Reset_n = 1'b0;
    #1;
    model_start();
    check("t5_rst_ready_busy", {in_ready, busy}, 64'd0);
    check("t5_rst_flags", {done, full, sat, sum_valid}, 64'd0);
    check("t5_rst_count", 64'(entry_count), 64'd0);
    check("t5_rst_outs", {sum_index, sum_data, rd_data}, 64'd0);
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    check("t5_idle_in_ready", 64'(in_ready), 64'd0);

    // 6a: random values with random in_valid gaps.
    pulse_start();
    for (int i = 0; i < 24; i++) vals[i] = $urandom_range(0, 4000);
    for (int i = 0; i < 24; i++) send_beat(vals[i], i == 23, $urandom_range(0, 3));
    check("t6a_count", 64'(entry_count), 64'd3);

    // 6b: gap-free frame with read-during-write on index 1.
    pulse_start();
    for (int i = 0; i < 24; i++) vals[i] = $urandom_range(0, 4000);
    for (int i = 0; i < 24; i++) begin
      if (i == 15) begin
        old_v   = shadow[1];
        rd_en   = 1'b1;
        rd_addr = 7'd1;
        send_beat(vals[i], 1'b0, 0);
        rd_en   = 1'b0;
        check("t6_read_first", 64'(rd_data), 64'(old_v));
        read_check("t6_read_new", 1, shadow[1]);
      end else begin
        send_beat(vals[i], i == 23, 0);
      end
    end
    check("t6b_done", 64'(done), 64'd1);
    read_check("t6_rd2", 2, shadow[2]);

    repeat (3) tick();
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
